// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, frame width and the
// parity helper used by both the Tx and Rx controllers.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_DONE   = 3'd5
    } uart_state_t;

    // Parity bit that makes the frame even (odd = 0) or odd (odd = 1).
    function automatic logic parity_of(
        input logic [DATA_BITS-1:0] d,
        input logic                 odd
    );
        return (^d) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter with synchronous clear and half-bit / full-bit
// strobes; shared by the UART Tx and Rx controllers.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic n_rst,
    input  logic i_clr,
    output logic o_end_half,
    output logic o_end_bit
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] r_cnt;

    assign o_end_half = (r_cnt == HALF);
    assign o_end_bit  = (r_cnt == LAST);

    // Wraps at the end of each bit so consecutive bits need no clear.
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            r_cnt <= '0;
        end else if (i_clr || o_end_bit) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver for 8 data bits, one parity bit and one stop bit,
// sampling each bit at its centre.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       parity_err,
    output logic       frame_err,
    output logic       rx_busy
);

    uart_state_t r_state;
    uart_state_t w_next;

    logic [1:0]           r_sync;
    logic                 r_prev;
    logic [DATA_BITS-1:0] r_sr;
    logic [2:0]           r_idx;
    logic                 r_par;
    logic [7:0]           r_data;
    logic                 r_perr;
    logic                 r_ferr;

    logic w_rx_s;
    logic w_fall;
    logic w_clr;
    logic w_end_half;
    logic w_end_bit;

    assign w_rx_s = r_sync[1];
    assign w_fall = r_prev & ~w_rx_s;
    assign w_clr  = (w_next != r_state);

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tick (
        .clk       (clk),
        .n_rst     (n_rst),
        .i_clr     (w_clr),
        .o_end_half(w_end_half),
        .o_end_bit (w_end_bit)
    );

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            r_sync <= 2'b11;
            r_prev <= 1'b1;
        end else begin
            r_sync <= {r_sync[0], rx};
            r_prev <= w_rx_s;
        end
    end

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        rx_busy = 1'b0;
        rx_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_fall) w_next = S_START;
            end
            S_START: begin
                rx_busy = 1'b1;
                if (w_end_half) w_next = w_rx_s ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                rx_busy = 1'b1;
                if (w_end_bit && r_idx == 3'(DATA_BITS - 1))
                    w_next = S_PARITY;
            end
            S_PARITY: begin
                rx_busy = 1'b1;
                if (w_end_bit) w_next = S_STOP;
            end
            S_STOP: begin
                rx_busy = 1'b1;
                if (w_end_bit) w_next = S_DONE;
            end
            S_DONE: begin
                rx_done = 1'b1;
                w_next  = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            r_sr  <= '0;
            r_idx <= '0;
            r_par <= 1'b0;
        end else begin
            if (r_state == S_START) r_idx <= '0;
            if (r_state == S_DATA && w_end_bit) begin
                r_sr  <= {w_rx_s, r_sr[DATA_BITS-1:1]};
                r_idx <= r_idx + 3'd1;
            end
            if (r_state == S_PARITY && w_end_bit) r_par <= w_rx_s;
        end
    end

    // Results load on the stop-bit sample so they are valid during DONE.
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            r_data <= 8'h00;
            r_perr <= 1'b0;
            r_ferr <= 1'b0;
        end else if (r_state == S_STOP && w_end_bit) begin
            r_data <= r_sr;
            r_perr <= parity_of(r_sr, PARITY_ODD) ^ r_par;
            r_ferr <= ~w_rx_s;
        end
    end

    assign rx_data    = r_data;
    assign parity_err = r_perr;
    assign frame_err  = r_ferr;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: directed frames on an even-parity
// and an odd-parity instance, with a decoupled rx_done monitor.
module tb_uart_rx_ctrl;

    localparam int CPB = 16;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic       clk = 1'b0;
    logic       n_rst = 1'b1;
    logic       rx = 1'b1;
    logic       rx2 = 1'b1;
    logic [7:0] rx_data, rx_data2;
    logic       rx_done, rx_done2;
    logic       parity_err, parity_err2;
    logic       frame_err, frame_err2;
    logic       rx_busy, rx_busy2;

    int checks = 0;
    int errors = 0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    uart_rx_ctrl #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1'b0)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .rx_busy   (rx_busy)
    );

    uart_rx_ctrl #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1'b1)) dut_odd (
        .clk       (clk),
        .n_rst     (n_rst),
        .rx        (rx2),
        .rx_data   (rx_data2),
        .rx_done   (rx_done2),
        .parity_err(parity_err2),
        .frame_err (frame_err2),
        .rx_busy   (rx_busy2)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int sel, input logic [7:0] d,
                        input logic pe, input logic fe);
        exp_t e;
        e.d  = d;
        e.pe = pe;
        e.fe = fe;
        if (sel == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic drive_bit(input int sel, input logic b);
        if (sel == 0) rx = b;
        else rx2 = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input int sel, input logic [7:0] d,
                              input logic par, input logic stop);
        drive_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
        drive_bit(sel, par);
        drive_bit(sel, stop);
    endtask

    task automatic idle_bits(input int n);
        rx  = 1'b1;
        rx2 = 1'b1;
        repeat (n * CPB) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rx_done) begin
            if (q0.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = q0.pop_front();
                check("rx_data", rx_data, e.d);
                check("parity_err", parity_err, e.pe);
                check("frame_err", frame_err, e.fe);
            end
        end
        if (rx_done2) begin
            if (q1.size() == 0) begin
                check("unexpected_done_odd", 1, 0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                check("rx_data_odd", rx_data2, e.d);
                check("parity_err_odd", parity_err2, e.pe);
                check("frame_err_odd", frame_err2, e.fe);
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_data", rx_data, 8'h00);
        check("rst_done", rx_done, 0);
        check("rst_perr", parity_err, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_busy", rx_busy, 0);
        n_rst = 1'b0;
        idle_bits(2);

        // 1: clean frame
        push(0, 8'hA5, 1'b0, 1'b0);
        send_frame(0, 8'hA5, 1'b0, 1'b1);
        idle_bits(2);
        check("busy_after_A5", rx_busy, 0);

        // 2: bad even parity, then good odd parity on the odd instance
        push(0, 8'h3C, 1'b1, 1'b0);
        send_frame(0, 8'h3C, 1'b1, 1'b1);
        idle_bits(2);
        push(1, 8'h3C, 1'b0, 1'b0);
        send_frame(1, 8'h3C, 1'b1, 1'b1);
        idle_bits(2);

        // 3: framing error, line held low, then recovery
        push(0, 8'h81, 1'b0, 1'b1);
        send_frame(0, 8'h81, 1'b0, 1'b0);
        rx = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        check("busy_while_low", rx_busy, 0);
        idle_bits(2);
        push(0, 8'h55, 1'b0, 1'b0);
        send_frame(0, 8'h55, 1'b0, 1'b1);
        idle_bits(2);

        // 4: short glitch rejected in START
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        check("busy_glitch", rx_busy, 1);
        repeat (CPB) @(negedge clk);
        check("busy_after_glitch", rx_busy, 0);
        idle_bits(1);

        // 5: reset during data bit 4 of 0xF0
        drive_bit(0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(0, 1'b0);
        rx = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        check("busy_before_rst", rx_busy, 1);
        n_rst = 1'b1;
        @(negedge clk);
        check("mid_rst_data", rx_data, 8'h00);
        check("mid_rst_busy", rx_busy, 0);
        check("mid_rst_done", rx_done, 0);
        check("mid_rst_perr", parity_err, 0);
        check("mid_rst_ferr", frame_err, 0);
        @(negedge clk);
        n_rst = 1'b0;
        idle_bits(3);
        check("post_rst_data", rx_data, 8'h00);
        push(0, 8'h0F, 1'b0, 1'b0);
        send_frame(0, 8'h0F, 1'b0, 1'b1);
        idle_bits(2);

        // 6: back-to-back frames
        push(0, 8'h00, 1'b0, 1'b0);
        push(0, 8'hFF, 1'b0, 1'b0);
        send_frame(0, 8'h00, 1'b0, 1'b1);
        send_frame(0, 8'hFF, 1'b0, 1'b1);
        idle_bits(3);

        check("pending_q0", q0.size(), 0);
        check("pending_q1", q1.size(), 0);
        check("final_data", rx_data, 8'hFF);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
